// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one request at a time over a req/ready handshake, with branch flush and stall handling.
module fetch_stage #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      op_code,
  output logic            valid_out,
  output logic [31:0]     fetch_count
);

  typedef enum logic {FETCH, REDIRECT} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [ILEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_out_reg;
  logic            valid_reg;
  logic [31:0]     fetch_count_reg;
  logic            accept;

  // The request is withdrawn in the same cycle as a stall or branch so memory never
  // commits to an address that is about to be abandoned.
  assign imem_req  = (state_reg == FETCH) && !stall && !branch_taken && !reset;
  assign imem_addr = pc_reg & ALIGN_MASK;
  assign accept    = imem_req && imem_ready;

  assign instr_out   = instr_reg;
  assign pc_out      = pc_out_reg;
  assign valid_out   = valid_reg;
  assign op_code     = instr_reg[6:0];
  assign fetch_count = fetch_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC & ALIGN_MASK;
      instr_reg       <= NOP_INSTR;
      pc_out_reg      <= '0;
      valid_reg       <= 1'b0;
      fetch_count_reg <= '0;
    end else if (branch_taken) begin
      // Any response arriving alongside the branch is on the wrong path and is dropped.
      state_reg <= REDIRECT;
      pc_reg    <= branch_target & ALIGN_MASK;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (stall) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= FETCH;
      if (accept) begin
        instr_reg  <= imem_rdata;
        pc_out_reg <= imem_addr;
        valid_reg  <= 1'b1;
        pc_reg     <= imem_addr + XLEN'(4);
        if (fetch_count_reg != 32'hFFFFFFFF) begin
          fetch_count_reg <= fetch_count_reg + 32'd1;
        end
      end else begin
        instr_reg <= NOP_INSTR;
        valid_reg <= 1'b0;
      end
    end
  end

endmodule
